// File: rtl/fpa_div_seq_if.sv
// Handshake and operand/result bundle for the sequential Q16.15 sign-magnitude divider.
interface fpa_div_seq_if;
  logic        start;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        ovf;
  logic        dz;

  modport master (
    output start, x1, x2,
    input  busy, done, y, ovf, dz
  );

  modport slave (
    input  start, x1, x2,
    output busy, done, y, ovf, dz
  );
endinterface

// File: rtl/fpa_div_seq.sv
// Restoring shift-subtract divider for sign-magnitude Q16.15, one quotient bit per clock.
// The dividend register doubles as the quotient register: quotient bits enter at the LSB.
module fpa_div_seq #(
  parameter int unsigned INT_BITS  = 16,
  parameter int unsigned FRAC_BITS = 15
) (
  input  logic          clk,
  input  logic          rst,
  fpa_div_seq_if.slave  bus
);

  localparam int unsigned MagW = INT_BITS + FRAC_BITS;
  localparam int unsigned N    = INT_BITS + 2 * FRAC_BITS;
  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [MagW-1:0] MagSat  = '1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [MagW-1:0] rem_q, rem_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [MagW-1:0] mb_q, mb_d;
  logic            rs_q, rs_d;
  logic [MagW:0]   y_q, y_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;

  logic [MagW:0]   rem_sh;
  logic [MagW:0]   diff;
  logic            ge;
  logic [N-1:0]    dvd_nxt;
  logic            ovf_c;
  logic [MagW-1:0] mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    mb_d    = mb_q;
    rs_d    = rs_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    // rem_q < mb_q always holds, so the borrow bit of diff alone decides R >= mb.
    rem_sh  = {rem_q, dvd_q[N-1]};
    diff    = rem_sh - {1'b0, mb_q};
    ge      = ~diff[MagW];
    dvd_nxt = {dvd_q[N-2:0], ge};
    ovf_c   = |dvd_nxt[N-1:MagW];
    mag     = ovf_c ? MagSat : dvd_nxt[MagW-1:0];

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          rs_d  = bus.x1[MagW] ^ bus.x2[MagW];
          mb_d  = bus.x2[MagW-1:0];
          dvd_d = {bus.x1[MagW-1:0], {FRAC_BITS{1'b0}}};
          rem_d = '0;
          cnt_d = '0;
          if (bus.x2[MagW-1:0] == '0) begin
            state_d = StDone;
            y_d     = {bus.x1[MagW] ^ bus.x2[MagW], MagSat};
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = ge ? diff[MagW-1:0] : rem_sh[MagW-1:0];
        dvd_d = dvd_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          y_d     = {rs_q & (|mag), mag};
          ovf_d   = ovf_c;
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      mb_q    <= '0;
      rs_q    <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      mb_q    <= mb_d;
      rs_q    <= rs_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.y    = y_q;
  assign bus.ovf  = ovf_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_fpa_div_seq.sv
// Bench for fpa_div_seq: arithmetic reference model plus per-cycle output compare and
// directed vectors with hand-computed results.
module tb_fpa_div_seq;

  logic clk = 1'b0;
  logic rst;

  fpa_div_seq_if bus ();

  fpa_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [33:0] r;
    int          reg_edge;
  } pend_t;

  pend_t       pend[$];
  int          free_at  = 0;
  logic        armed    = 1'b0;
  logic        done_exp = 1'b0;
  logic        busy_exp = 1'b0;
  logic [33:0] hold     = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {dz, ovf, y} from plain integer division of the magnitudes.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, qv;
    logic [30:0] mag;
    logic        rs, ov, z;
    ma  = longint'(a[30:0]);
    mb  = longint'(b[30:0]);
    rs  = a[31] ^ b[31];
    z   = (mb == 0);
    ov  = 1'b0;
    mag = 31'h7FFF_FFFF;
    if (!z) begin
      qv  = (ma << 15) / mb;
      ov  = (qv > 64'h7FFF_FFFF);
      mag = ov ? 31'h7FFF_FFFF : 31'(qv);
    end
    return {z, ov, rs && (mag != 0), mag};
  endfunction

  // Timing model: accept when idle, result registered lat-1 edges later, idle again after.
  initial begin : model
    int n;
    int lat;
    logic [33:0] r;
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      if (rst) begin
        pend.delete();
        free_at  = n + 1;
        hold     = '0;
        done_exp = 1'b0;
        busy_exp = 1'b0;
        armed    = 1'b1;
      end else begin
        if (bus.start && n >= free_at) begin
          r   = ref_div(bus.x1, bus.x2);
          lat = r[33] ? 1 : 47;
          pend.push_back('{r: r, reg_edge: n + lat - 1});
          free_at = n + lat + 1;
        end
        done_exp = 1'b0;
        if (pend.size() > 0 && pend[0].reg_edge == n) begin
          hold     = pend[0].r;
          done_exp = 1'b1;
          pend.pop_front();
        end
        busy_exp = (n < free_at - 1);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("done", 32'(bus.done), 32'(done_exp));
        chk("busy", 32'(bus.busy), 32'(busy_exp));
        chk("y",    bus.y,         hold[31:0]);
        chk("ovf",  32'(bus.ovf),  32'(hold[32]));
        chk("dz",   32'(bus.dz),   32'(hold[33]));
      end
    end
  end

  task automatic wait_done(inout int k);
    while (!bus.done && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one", k);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ey,
                        input logic eovf, input logic edz, input int elat);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x1    = a;
    bus.x2    = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x1    = $urandom;
    bus.x2    = $urandom;
    k = 1;
    wait_done(k);
    chk("op_latency", 32'(k), 32'(elat));
    chk("op_y",       bus.y, ey);
    chk("op_ovf",     32'(bus.ovf), 32'(eovf));
    chk("op_dz",      32'(bus.dz),  32'(edz));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    int ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x1    = '0;
    bus.x2    = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_y",    bus.y,         32'd0);
    rst = 1'b0;

    run_op(32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, 47);
    run_op(32'h8003_C000, 32'h0001_4000, 32'h8001_8000, 1'b0, 1'b0, 47);
    run_op(32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, 47);
    run_op(32'h7530_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1, 1'b0, 47);
    run_op(32'h8002_8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    run_op(32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 47);
    run_op(32'h8000_0001, 32'h0002_0000, 32'h0000_0000, 1'b0, 1'b0, 47);
    run_op(32'h8002_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 47);
    run_op(32'h0000_0001, 32'h8000_0001, 32'h8000_8000, 1'b0, 1'b0, 47);

    // Start re-asserted during CALC with other operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x1    = 32'h0001_8000;
    bus.x2    = 32'h0001_0000;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    repeat (10) begin @(negedge clk); k++; end
    bus.start = 1'b1;
    bus.x1    = 32'h0000_8000;
    bus.x2    = 32'h0001_8000;
    repeat (3) begin @(negedge clk); k++; end
    bus.start = 1'b0;
    wait_done(k);
    chk("busy_start_latency", 32'(k), 32'd47);
    chk("busy_start_y",       bus.y,  32'h0000_C000);

    // Start held high: one accept per 48 cycles, three done pulses in 144 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x1    = 32'h8003_C000;
    bus.x2    = 32'h0001_4000;
    ndone = 0;
    for (int i = 0; i < 144; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    chk("held_start_dones", 32'(ndone), 32'd3);
    chk("held_start_y",     bus.y,      32'h8001_8000);
    repeat (3) @(negedge clk);

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x1    = 32'h0001_8000;
    bus.x2    = 32'h0001_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_y",    bus.y,         32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    run_op(32'h8003_C000, 32'h0001_4000, 32'h8001_8000, 1'b0, 1'b0, 47);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
